// File: rtl/div_ctrl_if.sv
// EX-stage divider requester bundle: pipeline side (EX operands, stall, HI/LO write)
// and divider side (start/annul/operands out, result/ready in).
interface div_ctrl_if;
   logic        ex_div_valid_i;
   logic        ex_div_signed_i;
   logic [31:0] ex_reg1_i;
   logic [31:0] ex_reg2_i;
   logic        flush_i;
   logic        stall_o;
   logic        hilo_we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_opdata1_o;
   logic [31:0] div_opdata2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   // master: the controller; slave: pipeline control plus the divider
   modport master (
      input  ex_div_valid_i, ex_div_signed_i, ex_reg1_i, ex_reg2_i, flush_i,
             div_result_i, div_ready_i,
      output stall_o, hilo_we_o, hi_o, lo_o,
             div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o
   );
   modport slave (
      output ex_div_valid_i, ex_div_signed_i, ex_reg1_i, ex_reg2_i, flush_i,
             div_result_i, div_ready_i,
      input  stall_o, hilo_we_o, hi_o, lo_o,
             div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Execute-stage requester for the iterative divider: issues start, stalls EX while the
// divider runs, writes HI/LO for one cycle, and drains the divider after a flush.
module div_ctrl #(
   parameter int DRAIN_CYCLES = 2
) (
   input logic       clk,
   input logic       rst,
   div_ctrl_if.master bus
);
   localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

   state_t        state;
   logic          start_q;
   logic          annul_q;
   logic          signed_q;
   logic          hilo_we_q;
   logic [31:0]   op1_q;
   logic [31:0]   op2_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic [CW-1:0] drain_cnt;
   logic          issue;

   assign issue = bus.ex_div_valid_i & ~bus.flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         annul_q   <= 1'b0;
         signed_q  <= 1'b0;
         hilo_we_q <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         drain_cnt <= '0;
      end else begin
         annul_q   <= 1'b0;
         hilo_we_q <= 1'b0;
         case (state)
            IDLE: begin
               if (issue) begin
                  signed_q <= bus.ex_div_signed_i;
                  op1_q    <= bus.ex_reg1_i;
                  op2_q    <= bus.ex_reg2_i;
                  start_q  <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               // A flush wins over a same-cycle result: the killed instruction must not write
               if (bus.flush_i) begin
                  start_q   <= 1'b0;
                  annul_q   <= 1'b1;
                  drain_cnt <= CW'(DRAIN_CYCLES - 1);
                  state     <= DRAIN;
               end else if (bus.div_ready_i) begin
                  hi_q      <= bus.div_result_i[63:32];
                  lo_q      <= bus.div_result_i[31:0];
                  hilo_we_q <= 1'b1;
                  start_q   <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: state <= IDLE;
            DRAIN: begin
               if (drain_cnt == '0) state <= IDLE;
               else                 drain_cnt <= drain_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // DONE is the one cycle the instruction leaves EX, so it is never stalled
   assign bus.stall_o = ~rst & ((((state == IDLE) | (state == DRAIN)) & issue) |
                                (state == BUSY));

   assign bus.hilo_we_o     = hilo_we_q & ~bus.flush_i;
   assign bus.hi_o          = hi_q;
   assign bus.lo_o          = lo_q;
   assign bus.div_start_o   = start_q;
   assign bus.div_annul_o   = annul_q;
   assign bus.div_signed_o  = signed_q;
   assign bus.div_opdata1_o = op1_q;
   assign bus.div_opdata2_o = op2_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl against a cycle-level model of the iterative divider
// (free -> on x33 -> end, or free -> by-zero -> end).
module tb_div_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_ctrl_if bus ();

   div_ctrl #(.DRAIN_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int compared   = 0;
   int mismatched = 0;

   typedef enum logic [1:0] {D_FREE, D_ON, D_ZERO, D_END} dstate_t;
   dstate_t     ds;
   logic [5:0]  dcnt;
   logic [63:0] dres;
   logic [31:0] da, db;
   logic        dsg;

   function automatic logic [63:0] divide(input logic sg, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (sg) return {32'(sa % sb), 32'(sa / sb)};
      return {a % b, a / b};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ds <= D_FREE; dcnt <= '0; dres <= '0; da <= '0; db <= '0; dsg <= 1'b0;
         bus.div_ready_i  <= 1'b0;
         bus.div_result_i <= '0;
      end else begin
         case (ds)
            D_FREE: begin
               bus.div_ready_i  <= 1'b0;
               bus.div_result_i <= '0;
               if (bus.div_start_o && !bus.div_annul_o) begin
                  da <= bus.div_opdata1_o; db <= bus.div_opdata2_o; dsg <= bus.div_signed_o;
                  dcnt <= '0;
                  ds <= (bus.div_opdata2_o == 32'd0) ? D_ZERO : D_ON;
               end
            end
            D_ZERO: begin dres <= '0; ds <= D_END; end
            D_ON: begin
               if (bus.div_annul_o) ds <= D_FREE;
               else if (dcnt == 6'd32) begin dres <= divide(dsg, da, db); ds <= D_END; end
               else dcnt <= dcnt + 6'd1;
            end
            D_END: begin
               if (bus.div_start_o) begin
                  bus.div_ready_i <= 1'b1; bus.div_result_i <= dres;
               end else begin
                  bus.div_ready_i <= 1'b0; bus.div_result_i <= '0; ds <= D_FREE;
               end
            end
            default: ds <= D_FREE;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Holds one DIV in EX until its DONE cycle has passed; returns with EX empty in the next cycle
   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int pulses, output int start_at,
                          output logic [31:0] hi, output logic [31:0] lo, output logic [64:0] ops);
      bus.ex_div_valid_i = 1'b1; bus.ex_div_signed_i = sg;
      bus.ex_reg1_i = a; bus.ex_reg2_i = b;
      stalls = 0; pulses = 0; start_at = -1; hi = '0; lo = '0; ops = '0;
      for (int c = 0; c < 200 && pulses == 0; c++) begin
         @(negedge clk);
         if (bus.stall_o) stalls++;
         if (bus.div_start_o && start_at < 0) begin
            start_at = c;
            ops = {bus.div_signed_o, bus.div_opdata1_o, bus.div_opdata2_o};
         end
         if (bus.hilo_we_o) begin pulses++; hi = bus.hi_o; lo = bus.lo_o; end
         adv();
      end
      bus.ex_div_valid_i = 1'b0;
   endtask

   task automatic chk_idle_out(input string tag);
      chk({tag, " start"},   64'(bus.div_start_o),   64'd0);
      chk({tag, " annul"},   64'(bus.div_annul_o),   64'd0);
      chk({tag, " signed"},  64'(bus.div_signed_o),  64'd0);
      chk({tag, " opd1"},    64'(bus.div_opdata1_o), 64'd0);
      chk({tag, " opd2"},    64'(bus.div_opdata2_o), 64'd0);
      chk({tag, " hilo_we"}, 64'(bus.hilo_we_o),     64'd0);
      chk({tag, " hi"},      64'(bus.hi_o),          64'd0);
      chk({tag, " lo"},      64'(bus.lo_o),          64'd0);
   endtask

   int          st, pu, sa;
   logic [31:0] h, l;
   logic [64:0] op;
   logic        found;

   initial begin
      rst = 1'b1;
      bus.flush_i = 1'b0;
      bus.ex_div_valid_i = 1'b1; bus.ex_div_signed_i = 1'b1;
      bus.ex_reg1_i = 32'd5; bus.ex_reg2_i = 32'd1;
      adv(); adv();
      @(negedge clk);
      chk("rst stall", 64'(bus.stall_o), 64'd0);
      chk_idle_out("rst");
      adv();
      rst = 1'b0; bus.ex_div_valid_i = 1'b0;

      // 100 / 7 signed
      run_div(1'b1, 32'd100, 32'd7, st, pu, sa, h, l, op);
      chk("d100_7 pulses", 64'(pu), 64'd1);
      chk("d100_7 stalls", 64'(st), 64'd37);
      chk("d100_7 start_at", 64'(sa), 64'd1);
      chk("d100_7 lo", 64'(l), 64'd14);
      chk("d100_7 hi", 64'(h), 64'd2);
      @(negedge clk);
      chk("d100_7 single pulse", 64'(bus.hilo_we_o), 64'd0);
      chk("d100_7 lo hold", 64'(bus.lo_o), 64'd14);
      chk("d100_7 hi hold", 64'(bus.hi_o), 64'd2);
      adv();

      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, st, pu, sa, h, l, op);
      chk("dneg7_2 pulses", 64'(pu), 64'd1);
      chk("dneg7_2 lo", 64'(l), 64'hFFFF_FFFD);
      chk("dneg7_2 hi", 64'(h), 64'hFFFF_FFFF);
      chk("dneg7_2 operands", 64'(op[63:0]), 64'hFFFF_FFF9_0000_0002);
      chk("dneg7_2 signed", 64'(op[64]), 64'd1);

      run_div(1'b0, 32'hFFFF_FFFF, 32'h10, st, pu, sa, h, l, op);
      chk("divu pulses", 64'(pu), 64'd1);
      chk("divu stalls", 64'(st), 64'd37);
      chk("divu lo", 64'(l), 64'h0FFF_FFFF);
      chk("divu hi", 64'(h), 64'hF);
      chk("divu signed", 64'(op[64]), 64'd0);

      // divide by zero: 6 cycles of EX occupancy
      run_div(1'b1, 32'd1234, 32'd0, st, pu, sa, h, l, op);
      chk("dz pulses", 64'(pu), 64'd1);
      chk("dz stalls", 64'(st), 64'd5);
      chk("dz start_at", 64'(sa), 64'd1);
      chk("dz lo", 64'(l), 64'd0);
      chk("dz hi", 64'(h), 64'd0);

      // flush in BUSY cycle 10
      bus.ex_div_valid_i = 1'b1; bus.ex_div_signed_i = 1'b1;
      bus.ex_reg1_i = 32'd1000; bus.ex_reg2_i = 32'd3;
      repeat (10) adv();
      bus.flush_i = 1'b1;
      @(negedge clk);
      chk("fl busy stall", 64'(bus.stall_o), 64'd1);
      chk("fl busy start", 64'(bus.div_start_o), 64'd1);
      chk("fl busy annul", 64'(bus.div_annul_o), 64'd0);
      adv();
      bus.flush_i = 1'b0; bus.ex_div_valid_i = 1'b0;
      @(negedge clk);
      chk("fl dr1 annul", 64'(bus.div_annul_o), 64'd1);
      chk("fl dr1 start", 64'(bus.div_start_o), 64'd0);
      chk("fl dr1 hilo", 64'(bus.hilo_we_o), 64'd0);
      chk("fl dr1 stall", 64'(bus.stall_o), 64'd0);
      adv();
      bus.ex_div_valid_i = 1'b1; bus.ex_reg1_i = 32'd9; bus.ex_reg2_i = 32'd3;
      @(negedge clk);
      chk("fl dr2 annul", 64'(bus.div_annul_o), 64'd0);
      chk("fl dr2 start", 64'(bus.div_start_o), 64'd0);
      chk("fl dr2 stall", 64'(bus.stall_o), 64'd1);
      chk("fl dr2 hilo", 64'(bus.hilo_we_o), 64'd0);
      adv();
      run_div(1'b1, 32'd9, 32'd3, st, pu, sa, h, l, op);
      chk("d9_3 start_at", 64'(sa), 64'd1);
      chk("d9_3 stalls", 64'(st), 64'd37);
      chk("d9_3 pulses", 64'(pu), 64'd1);
      chk("d9_3 lo", 64'(l), 64'd3);
      chk("d9_3 hi", 64'(h), 64'd0);

      // back-to-back: second issues in the IDLE cycle right after the first DONE
      run_div(1'b1, 32'd20, 32'd6, st, pu, sa, h, l, op);
      chk("b2b1 lo", 64'(l), 64'd3);
      chk("b2b1 hi", 64'(h), 64'd2);
      run_div(1'b1, 32'd20, 32'd5, st, pu, sa, h, l, op);
      chk("b2b2 start_at", 64'(sa), 64'd1);
      chk("b2b2 stalls", 64'(st), 64'd37);
      chk("b2b2 pulses", 64'(pu), 64'd1);
      chk("b2b2 lo", 64'(l), 64'd4);
      chk("b2b2 hi", 64'(h), 64'd0);

      // flush coincident with div_ready_i
      bus.ex_div_valid_i = 1'b1; bus.ex_div_signed_i = 1'b0;
      bus.ex_reg1_i = 32'd50; bus.ex_reg2_i = 32'd5;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (bus.div_ready_i) found = 1'b1;
         else adv();
      end
      chk("flr ready seen", 64'(found), 64'd1);
      bus.flush_i = 1'b1;
      adv();
      bus.flush_i = 1'b0; bus.ex_div_valid_i = 1'b0;
      @(negedge clk);
      chk("flr hilo", 64'(bus.hilo_we_o), 64'd0);
      chk("flr annul", 64'(bus.div_annul_o), 64'd1);
      chk("flr start", 64'(bus.div_start_o), 64'd0);
      adv();
      @(negedge clk);
      chk("flr dr2 hilo", 64'(bus.hilo_we_o), 64'd0);
      chk("flr dr2 stall", 64'(bus.stall_o), 64'd0);
      adv();
      @(negedge clk);
      chk("flr idle hilo", 64'(bus.hilo_we_o), 64'd0);
      chk("flr lo kept", 64'(bus.lo_o), 64'd4);
      chk("flr hi kept", 64'(bus.hi_o), 64'd0);
      adv();

      // flush during DONE gates the write
      bus.ex_div_valid_i = 1'b1; bus.ex_div_signed_i = 1'b0;
      bus.ex_reg1_i = 32'd30; bus.ex_reg2_i = 32'd4;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (bus.div_ready_i) found = 1'b1;
         else adv();
      end
      chk("fld ready seen", 64'(found), 64'd1);
      adv();
      bus.flush_i = 1'b1;
      @(negedge clk);
      chk("fld hilo gated", 64'(bus.hilo_we_o), 64'd0);
      chk("fld stall", 64'(bus.stall_o), 64'd0);
      adv();
      bus.flush_i = 1'b0; bus.ex_div_valid_i = 1'b0;
      @(negedge clk);
      chk("fld after hilo", 64'(bus.hilo_we_o), 64'd0);
      adv();

      // reset in mid-BUSY
      bus.ex_div_valid_i = 1'b1; bus.ex_div_signed_i = 1'b1;
      bus.ex_reg1_i = 32'd100; bus.ex_reg2_i = 32'd7;
      repeat (6) adv();
      rst = 1'b1;
      @(negedge clk);
      chk("mrst stall", 64'(bus.stall_o), 64'd0);
      adv();
      rst = 1'b0; bus.ex_div_valid_i = 1'b0;
      @(negedge clk);
      chk_idle_out("mrst");
      chk("mrst idle stall", 64'(bus.stall_o), 64'd0);
      adv();
      run_div(1'b0, 32'd7, 32'd7, st, pu, sa, h, l, op);
      chk("post rst start_at", 64'(sa), 64'd1);
      chk("post rst stalls", 64'(st), 64'd37);
      chk("post rst lo", 64'(l), 64'd1);
      chk("post rst hi", 64'(h), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end
endmodule
